// File: rtl/tx_pkg.sv
// tx_pkg: state encoding, legal parameter ranges and frame sizing helpers
// shared by the UART TX frame engine.
// Build option: define TX_PARITY_EN to insert one parity bit after the data.
package tx_pkg;

  // Frame phases in transmit order
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

`ifdef TX_PARITY_EN
  localparam int TX_PARITY_BITS = 1;
`else
  localparam int TX_PARITY_BITS = 0;
`endif

  // Number of bit periods in one frame: start + data + parity + stop
  function automatic int tx_frame_len(input int data_width, input int stop_bits);
    return 1 + data_width + TX_PARITY_BITS + stop_bits;
  endfunction

  // Width of an index able to address every bit of the frame
  function automatic int tx_cnt_width(input int frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// tx_bit_counter: baud-tick enabled index of the frame bit currently on the
// line. Saturates at MAX_VAL, synchronous clear from the FSM, async clear.
module tx_bit_counter #(
  parameter int MAX_VAL = 9,
  parameter int CNT_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next index: clear wins, then increment unless already at the last bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q < MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Index register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: UART TX frame engine. Accepts a word while idle and
// serialises it LSB-first as start + data + [parity] + stop bits, one bit
// per baud_tick. All outputs come straight from flops.
// Build option: TX_PARITY_EN adds the parity_odd port and a parity bit.
module tx_frame_sequencer
  import tx_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  STOP_BITS  = 1,
  localparam int FRAME_LEN  = tx_frame_len(DATA_WIDTH, STOP_BITS),
  localparam int CNT_W      = tx_cnt_width(FRAME_LEN)
) (
  input  logic                  tx_clk,
  input  logic                  tx_arst_n,
  input  logic                  baud_tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  output logic                  baud_sync,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [CNT_W-1:0]      bit_select,
  output logic                  tx_serial
);

  localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(FRAME_LEN - 1);

  tx_state_e             state_q,  state_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic                  serial_q, serial_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  sync_q,   sync_d;
  logic                  cnt_inc_s;
  logic                  cnt_clr_s;
  logic [CNT_W-1:0]      cnt_s;

`ifdef TX_PARITY_EN
  logic par_q, par_d;

  // Parity bit for a word: even parity by default, inverted for odd
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction
`endif

  tx_bit_counter #(
    .MAX_VAL (FRAME_LEN - 1),
    .CNT_W   (CNT_W)
  ) u_bit_counter (
    .clk_i  (tx_clk),
    .rst_ni (tx_arst_n),
    .inc_i  (cnt_inc_s),
    .clr_i  (cnt_clr_s),
    .cnt_o  (cnt_s)
  );

  // Frame FSM: next state, shifter, line level and handshake pulses
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sync_d    = 1'b0;
    cnt_inc_s = 1'b0;
    cnt_clr_s = 1'b0;
`ifdef TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        serial_d  = 1'b1;
        busy_d    = 1'b0;
        cnt_clr_s = 1'b1;
        // The tx_done cycle still counts as busy for new requests
        if (tx_start && !done_q) begin
          shift_d  = tx_data;
`ifdef TX_PARITY_EN
          par_d    = calc_parity(tx_data, parity_odd);
`endif
          state_d  = ST_START;
          busy_d   = 1'b1;
          serial_d = 1'b0;
          sync_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
          cnt_inc_s = 1'b1;
        end else begin
          state_d   = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          cnt_inc_s = 1'b1;
          if (cnt_s == LAST_DATA_IDX) begin
`ifdef TX_PARITY_EN
            state_d  = ST_PARITY;
            serial_d = par_q;
`else
            state_d  = ST_STOP;
            serial_d = 1'b1;
`endif
          end else begin
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[DATA_WIDTH-1:1]};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d   = ST_STOP;
          serial_d  = 1'b1;
          cnt_inc_s = 1'b1;
        end else begin
          state_d   = ST_PARITY;
        end
      end
      ST_STOP: begin
        serial_d = 1'b1;
        if (baud_tick) begin
          if (cnt_s == LAST_IDX) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cnt_clr_s = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        serial_d  = 1'b1;
        busy_d    = 1'b0;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State, shifter and registered outputs; reset aborts any frame in flight
  always_ff @(posedge tx_clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= {DATA_WIDTH{1'b0}};
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sync_q   <= sync_d;
    end
  end

`ifdef TX_PARITY_EN
  // Parity bit captured with the word at acceptance
  always_ff @(posedge tx_clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx_serial  = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign baud_sync  = sync_q;
  assign bit_select = cnt_s;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: an 8-data/1-stop instance (a) and a
// 5-data/2-stop instance (b), each checked cycle by cycle against a frame
// model built as a list of expected line bits.
module tb_tx_frame_sequencer;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int A_DW = 8;
  localparam int A_SB = 1;
  localparam int B_DW = 5;
  localparam int B_SB = 2;
  localparam int A_CW = $clog2(1 + A_DW + PAR + A_SB);
  localparam int B_CW = $clog2(1 + B_DW + PAR + B_SB);

  logic            tx_clk = 1'b0;
  logic            tx_arst_n;
  logic            baud_tick;
  logic            a_start, b_start;
  logic [A_DW-1:0] a_data;
  logic [B_DW-1:0] b_data;
  logic            a_sync, a_busy, a_done, a_serial;
  logic            b_sync, b_busy, b_done, b_serial;
  logic [A_CW-1:0] a_bs;
  logic [B_CW-1:0] b_bs;
`ifdef TX_PARITY_EN
  logic            a_odd, b_odd;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tx_clk = ~tx_clk;

  tx_frame_sequencer #(.DATA_WIDTH(A_DW), .STOP_BITS(A_SB)) dut_a (
    .tx_clk     (tx_clk),
    .tx_arst_n  (tx_arst_n),
    .baud_tick  (baud_tick),
    .tx_start   (a_start),
    .tx_data    (a_data),
`ifdef TX_PARITY_EN
    .parity_odd (a_odd),
`endif
    .baud_sync  (a_sync),
    .tx_busy    (a_busy),
    .tx_done    (a_done),
    .bit_select (a_bs),
    .tx_serial  (a_serial)
  );

  tx_frame_sequencer #(.DATA_WIDTH(B_DW), .STOP_BITS(B_SB)) dut_b (
    .tx_clk     (tx_clk),
    .tx_arst_n  (tx_arst_n),
    .baud_tick  (baud_tick),
    .tx_start   (b_start),
    .tx_data    (b_data),
`ifdef TX_PARITY_EN
    .parity_odd (b_odd),
`endif
    .baud_sync  (b_sync),
    .tx_busy    (b_busy),
    .tx_done    (b_done),
    .bit_select (b_bs),
    .tx_serial  (b_serial)
  );

  // Observed outputs packed as {serial, busy, done, sync, bit_select[3:0]}
  function automatic logic [7:0] obs(input int which);
    if (which == 0) return {a_serial, a_busy, a_done, a_sync, 4'(a_bs)};
    else            return {b_serial, b_busy, b_done, b_sync, 4'(b_bs)};
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) a_start = v;
    else            b_start = v;
  endtask

  task automatic set_word(input int which, input logic [8:0] data, input logic odd);
    if (which == 0) a_data = data[A_DW-1:0];
    else            b_data = data[B_DW-1:0];
`ifdef TX_PARITY_EN
    if (which == 0) a_odd = odd;
    else            b_odd = odd;
`endif
  endtask

  // Sends one frame and checks every cycle. poke_bit: pulse tx_start during
  // that bit; poke_done: pulse tx_start in the tx_done cycle; abort_bit:
  // reset during that bit; gap_bit: that bit lasts 100 clocks.
  task automatic run_frame(input int which, input logic [8:0] data, input logic odd,
                           input int pmin, input int pmax, input int poke_bit,
                           input bit poke_done, input int abort_bit,
                           input int gap_bit, input bit tick_acc);
    logic       exp_bits[$];
    logic       par;
    logic [7:0] exp_v, got_v;
    int         dw, sb, fl, idx, per;
    bit         first, aborted;
    dw  = (which == 0) ? A_DW : B_DW;
    sb  = (which == 0) ? A_SB : B_SB;
    par = odd;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      exp_bits.push_back(data[i]);
      par = par ^ data[i];
    end
    if (PAR == 1) exp_bits.push_back(par);
    for (int i = 0; i < sb; i++) exp_bits.push_back(1'b1);
    fl = exp_bits.size();

    set_word(which, data, odd);
    set_start(which, 1'b1);
    baud_tick = tick_acc;
    @(negedge tx_clk);
    set_start(which, 1'b0);
    set_word(which, 9'($urandom), 1'($urandom));
    baud_tick = 1'b0;
    idx = 0; first = 1'b1; aborted = 1'b0;
    while (idx < fl && !aborted) begin
      per = (idx == gap_bit) ? 100 : int'($urandom_range(pmax, pmin));
      if (idx == abort_bit && per < 3) per = 3;
      for (int k = 0; k < per && !aborted; k++) begin
        exp_v = {exp_bits[idx], 1'b1, 1'b0, first, 4'(idx)};
        got_v = obs(which);
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL frame dut%0d bit%0d cyc%0d: got %b required %b", which, idx, k, got_v, exp_v);
        end
        first = 1'b0;
        if (idx == abort_bit && k == 1) begin
          tx_arst_n = 1'b0;
          #1;
          got_v = obs(which);
          n_cmp++;
          if (got_v !== 8'h80) begin
            n_bad++;
            $display("FAIL abort_instant dut%0d: got %b required %b", which, got_v, 8'h80);
          end
          aborted = 1'b1;
        end else begin
          baud_tick = (k == per - 1);
          set_start(which, (idx == poke_bit) && (k == 0));
          @(negedge tx_clk);
        end
      end
      baud_tick = 1'b0;
      idx++;
    end
    set_start(which, 1'b0);

    if (aborted) begin
      repeat (3) @(negedge tx_clk);
      tx_arst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge tx_clk);
        got_v = obs(which);
        n_cmp++;
        if (got_v !== 8'h80) begin
          n_bad++;
          $display("FAIL after_abort dut%0d cyc%0d: got %b required %b", which, k, got_v, 8'h80);
        end
      end
    end else begin
      got_v = obs(which);
      n_cmp++;
      if (got_v !== 8'hA0) begin
        n_bad++;
        $display("FAIL done_cycle dut%0d: got %b required %b", which, got_v, 8'hA0);
      end
      set_start(which, poke_done);
      @(negedge tx_clk);
      set_start(which, 1'b0);
      got_v = obs(which);
      n_cmp++;
      if (got_v !== 8'h80) begin
        n_bad++;
        $display("FAIL after_done dut%0d: got %b required %b", which, got_v, 8'h80);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got_v;
    tx_arst_n = 1'b0;
    repeat (3) @(negedge tx_clk);
    for (int w = 0; w < 2; w++) begin
      got_v = obs(w);
      n_cmp++;
      if (got_v !== 8'h80) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got %b required %b", w, got_v, 8'h80);
      end
    end
    tx_arst_n = 1'b1;
    repeat (2) @(negedge tx_clk);
    got_v = obs(0);
    n_cmp++;
    if (got_v !== 8'h80) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b required %b", got_v, 8'h80);
    end
  endtask

  task automatic test_8n1();
    run_frame(0, 9'h0A5, 1'b0, 16, 16, -1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_parity();
    run_frame(0, 9'h003, 1'b0, 2, 5, -1, 1'b0, -1, -1, 1'b0);
    run_frame(0, 9'h003, 1'b1, 2, 5, -1, 1'b0, -1, -1, 1'b0);
    run_frame(1, 9'h003, 1'b1, 2, 5, -1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_dw5();
    run_frame(1, 9'h1FF, 1'b0, 3, 6, -1, 1'b0, -1, -1, 1'b0);
    run_frame(1, 9'h0E0, 1'b1, 1, 3, -1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_busy();
    run_frame(0, 9'($urandom), 1'($urandom), 3, 6, 4, 1'b1, -1, -1, 1'b0);
    run_frame(0, 9'($urandom), 1'($urandom), 2, 4, -1, 1'b1, -1, -1, 1'b0);
    run_frame(1, 9'($urandom), 1'($urandom), 2, 4, 2, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_frame(0, 9'h0FF, 1'b1, 3, 5, -1, 1'b0, 5, -1, 1'b0);
    run_frame(0, 9'h000, 1'b0, 2, 4, -1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_gaps();
    run_frame(0, 9'($urandom), 1'($urandom), 2, 4, -1, 1'b0, -1, 3, 1'b1);
    run_frame(1, 9'($urandom), 1'($urandom), 2, 4, -1, 1'b0, -1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_frame(int'($urandom_range(1, 0)), 9'($urandom), 1'($urandom), 1, 4,
                int'($urandom_range(9, 0)), 1'($urandom), -1, -1, 1'($urandom));
    end
  endtask

  initial begin
    tx_arst_n = 1'b0;
    baud_tick = 1'b0;
    a_start   = 1'b0;
    b_start   = 1'b0;
    a_data    = '0;
    b_data    = '0;
`ifdef TX_PARITY_EN
    a_odd     = 1'b0;
    b_odd     = 1'b0;
`endif
    test_reset();
    test_8n1();
    test_parity();
    test_dw5();
    test_busy();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
